// File: rtl/cla_16_if.sv
// Operand/result bundle for the 16-bit pipelined carry-lookahead adder.
interface cla_16_if;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic [15:0] s;
   logic        cout;

   // Operand source: drives a/b/cin, observes the registered result.
   modport master (output a, output b, output cin, input s, input cout);
   // Adder: consumes operands, drives the registered result.
   modport slave  (input a, input b, input cin, output s, output cout);
endinterface

// File: rtl/cla_16.sv
// 16-bit two-stage pipelined carry-lookahead adder: {cout,s} = a + b + cin.
// Input register stage -> two-level CLA core (4 groups x 4 bits) -> output
// register stage. One operand set per clock, result two edges after capture.
module cla_16 (
   input  logic     clk,
   input  logic     rst_b,
   cla_16_if.slave  bus
);

   logic [15:0] a_q;
   logic [15:0] b_q;
   logic        cin_q;
   logic [15:0] s_q;
   logic        cout_q;

   logic [15:0] g;
   logic [15:0] p;
   logic [16:0] c;
   logic [3:0]  grp_g;
   logic [3:0]  grp_p;
   logic [4:0]  grp_c;
   logic [15:0] sum;

   // Input register stage: capture operands every edge, clear on reset.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         a_q   <= '0;
         b_q   <= '0;
         cin_q <= 1'b0;
      end else begin
         a_q   <= bus.a;
         b_q   <= bus.b;
         cin_q <= bus.cin;
      end
   end

   // CLA core: bit g/p, group G/P, second-level lookahead for group carries,
   // then in-group lookahead from each group's carry-in. No inter-group ripple.
   always_comb begin
      g     = a_q & b_q;
      p     = a_q ^ b_q;
      grp_g = '0;
      grp_p = '0;
      grp_c = '0;
      c     = '0;
      sum   = '0;

      for (int unsigned k = 0; k < 4; k++) begin
         grp_g[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      end

      grp_c[0] = cin_q;
      grp_c[1] = grp_g[0] | (grp_p[0] & cin_q);
      grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0])
               | (grp_p[1] & grp_p[0] & cin_q);
      grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1])
               | (grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[2] & grp_p[1] & grp_p[0] & cin_q);
      grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2])
               | (grp_p[3] & grp_p[2] & grp_g[1])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin_q);

      for (int unsigned k = 0; k < 4; k++) begin
         c[4*k]   = grp_c[k];
         c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                  | (p[4*k+1] & p[4*k] & grp_c[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                  | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
      end
      c[16] = grp_c[4];

      sum = p ^ c[15:0];
   end

   // Output register stage: capture the core result, clear on reset.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         s_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         s_q    <= sum;
         cout_q <= c[16];
      end
   end

   assign bus.s    = s_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_cla_16.sv
// Directed bench for cla_16: hand-computed vectors plus incrementing sweeps,
// with a two-deep expected-value pipeline mirroring the register latency.
module tb_cla_16;

   logic clk;
   logic rst_b;
   int   total;
   int   bad;

   logic [16:0] exp_in;
   logic [16:0] exp_out;

   cla_16_if bus ();

   cla_16 dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare the registered result with the expected value two edges back.
   task automatic check(input string tag);
      total++;
      assert ({bus.cout, bus.s} === exp_out)
      else begin
         bad++;
         $error("FAIL %s: got cout=%b s=%h want cout=%b s=%h",
                tag, bus.cout, bus.s, exp_out[16], exp_out[15:0]);
      end
   endtask

   // Apply one operand set (or reset) for one edge, then check the output.
   task automatic cyc(input logic [15:0] ta, input logic [15:0] tb_v,
                      input logic tc, input logic tr,
                      input logic [16:0] texp, input string tag);
      bus.a   = ta;
      bus.b   = tb_v;
      bus.cin = tc;
      rst_b   = tr;
      @(posedge clk);
      #1;
      if (tr) begin
         exp_out = '0;
         exp_in  = '0;
      end else begin
         exp_out = exp_in;
         exp_in  = texp;
      end
      check(tag);
   endtask

   initial begin
      logic [15:0] av;
      logic [15:0] bv;
      total   = 0;
      bad     = 0;
      exp_in  = '0;
      exp_out = '0;
      bus.a   = '0;
      bus.b   = '0;
      bus.cin = 1'b0;
      rst_b   = 1'b1;

      // Reset held two edges, then zeros flow through.
      cyc(16'h0000, 16'h0000, 1'b0, 1'b1, 17'h00000, "reset0");
      cyc(16'h0000, 16'h0000, 1'b0, 1'b1, 17'h00000, "reset1");
      cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 17'h00000, "zero0");
      cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 17'h00000, "zero1");

      // Hand-computed directed vectors.
      cyc(16'h0000, 16'hFFFF, 1'b0, 1'b0, 17'h0FFFF, "0+ffff");
      cyc(16'h0000, 16'hFFFF, 1'b1, 1'b0, 17'h10000, "0+ffff+1");
      cyc(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, "ffff+1");
      cyc(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF, "ffff+ffff+1");
      cyc(16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, "1234+4321");
      cyc(16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000, "8000+8000");
      cyc(16'hAAAA, 16'h5555, 1'b0, 1'b0, 17'h0FFFF, "aaaa+5555");
      cyc(16'hAAAA, 16'h5555, 1'b1, 1'b0, 17'h10000, "aaaa+5555+1");
      cyc(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 17'h01000, "0f0f+00f1");
      cyc(16'h7FFF, 16'h0000, 1'b1, 1'b0, 17'h08000, "7fff+0+1");

      // Back-to-back: b=FFFF, cin=1, a increments; result is {1,a}.
      for (int i = 0; i < 1024; i++) begin
         av = 16'(i);
         cyc(av, 16'hFFFF, 1'b1, 1'b0, {1'b1, av}, "sweep_a");
      end

      // a=03FF, cin=1, b runs FFFF upward and wraps to 03FE.
      bv = 16'hFFFF;
      for (int i = 0; i < 1024; i++) begin
         cyc(16'h03FF, bv, 1'b1, 1'b0,
             17'({1'b0, 16'h03FF} + {1'b0, bv} + 17'd1), "sweep_b");
         bv = bv + 16'd1;
      end

      // One-edge reset mid-stream, then refill.
      cyc(16'h1111, 16'h2222, 1'b0, 1'b0, 17'h03333, "pre_rst0");
      cyc(16'h4444, 16'h4444, 1'b1, 1'b0, 17'h08889, "pre_rst1");
      cyc(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 17'h00000, "mid_rst");
      cyc(16'hC000, 16'h4000, 1'b0, 1'b0, 17'h10000, "refill0");
      cyc(16'h0001, 16'h0002, 1'b1, 1'b0, 17'h00004, "refill1");
      cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 17'h00000, "refill2");
      cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 17'h00000, "refill3");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
